// File: rtl/ram_32x8.sv
// ram_32x8
//   Single-port 32-word x 8-bit scratch memory for the datapath.
//   One shared address selects the word for both write and read. Writes are
//   synchronous on the rising clock edge. Reset_n clears the whole array
//   asynchronously. Storage is built from discrete flops so that every word
//   can be cleared.
//
// Configuration macro
//   RAM32X8_OUTREG_EN  defined   : outData is registered (read-first, 1-cycle
//                                  latency, async reset to RESET_VALUE)
//                      undefined : outData is a combinational read of
//                                  mem[Address] (0-cycle latency)
//
// Ports
//   Clock    in   1           system clock, rising-edge active
//   Reset_n  in   1           asynchronous reset, active low
//   Address  in   ADDR_WIDTH  word select for write and read
//   WE       in   1           write enable, active high
//   inData   in   DATA_WIDTH  write data
//   outData  out  DATA_WIDTH  read data of mem[Address]
module ram_32x8 #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    DEPTH       = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 8'h00
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] inData,
  output logic [DATA_WIDTH-1:0] outData
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]      word_we_s;

  // One-hot write strobe per word. An X/Z on WE selects the else branch in
  // simulation, so an unknown enable never writes.
  always_comb begin
    word_we_s = '0;
    if (WE == 1'b1) begin
      word_we_s[Address] = 1'b1;
    end else begin
      word_we_s = '0;
    end
  end

  // Storage array: async clear of every word, otherwise write the strobed word.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we_s[i]) begin
          mem_r[i] <= inData;
        end
      end
    end
  end

`ifdef RAM32X8_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_data_r;

  // Registered read port. It samples the array before this edge's write
  // lands, so a same-address write returns the old word (read-first).
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_data_r <= RESET_VALUE;
    end else begin
      out_data_r <= mem_r[Address];
    end
  end

  assign outData = out_data_r;
`else
  // Combinational read. There is no write bypass: the new word appears only
  // after the edge that stores it.
  assign outData = mem_r[Address];
`endif

endmodule

// File: tb/tb_ram_32x8.sv
// tb_ram_32x8
//   Directed self-checking bench for ram_32x8. The expected values are
//   hand-computed constants. Read timing follows RAM32X8_OUTREG_EN, so the
//   same vectors work for both builds.
module tb_ram_32x8;

  logic       Clock;
  logic       Reset_n;
  logic [4:0] Address;
  logic       WE;
  logic [7:0] inData;
  logic [7:0] outData;

  int checks = 0;
  int errors = 0;

  ram_32x8 dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Address (Address),
    .WE      (WE),
    .inData  (inData),
    .outData (outData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single write: drive on the falling edge, store on the next rising edge.
  task automatic write_word(input logic [4:0] a, input logic [7:0] d);
    @(negedge Clock);
    Address = a;
    inData  = d;
    WE      = 1'b1;
    @(negedge Clock);
    WE      = 1'b0;
  endtask

  // Present an address and sample outData after the build's read latency.
  task automatic read_word(input logic [4:0] a, output logic [7:0] d);
    @(negedge Clock);
    Address = a;
`ifdef RAM32X8_OUTREG_EN
    @(posedge Clock);
`endif
    #1;
    d = outData;
  endtask

  logic [7:0] rd;
  logic [7:0] expv;

  initial begin
    Reset_n = 1'b0;
    Address = 5'd10;
    WE      = 1'b0;
    inData  = 8'h00;

    // Reset asserted: outData must already read as the reset value.
    #2;
    check_eq("reset_held_out", outData, 8'h00);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    // Test 1: words 0, 10 and 31 cleared.
    read_word(5'd0, rd);  check_eq("t1_addr0", rd, 8'h00);
    read_word(5'd10, rd); check_eq("t1_addr10", rd, 8'h00);
    read_word(5'd31, rd); check_eq("t1_addr31", rd, 8'h00);

    // Test 2: write 1 to word 0, then one edge with WE=0 and inData=5.
    write_word(5'd0, 8'd1);
    inData = 8'd5;
    @(negedge Clock);
    read_word(5'd0, rd); check_eq("t2_addr0", rd, 8'd1);

    // Test 3: write 100 to word 10, then one edge with WE=0 and inData=55.
    write_word(5'd10, 8'd100);
    inData = 8'd55;
    @(negedge Clock);
    read_word(5'd10, rd); check_eq("t3_addr10", rd, 8'd100);

    // Test 4: overwrite word 10; word 0 must be untouched.
    write_word(5'd10, 8'd10);
    inData = 8'd0;
    @(negedge Clock);
    read_word(5'd10, rd); check_eq("t4_addr10", rd, 8'd10);
    read_word(5'd0, rd);  check_eq("t4_addr0", rd, 8'd1);

`ifndef RAM32X8_OUTREG_EN
    // Same-address read during write: old word before the edge, new word after it.
    @(negedge Clock);
    Address = 5'd10;
    inData  = 8'h77;
    WE      = 1'b1;
    #1;
    check_eq("rdw_before", outData, 8'd10);
    @(posedge Clock);
    #1;
    check_eq("rdw_after", outData, 8'h77);
    @(negedge Clock);
    WE = 1'b0;
    // The address changes without a clock edge and the read follows it.
    Address = 5'd0;
    #1;
    check_eq("async_addr_change", outData, 8'd1);
`endif

    // An X on WE at the clock edge must not write.
    @(negedge Clock);
    Address = 5'd5;
    inData  = 8'hEE;
    WE      = 1'bx;
    @(negedge Clock);
    WE = 1'b0;
    read_word(5'd5, rd); check_eq("we_x_no_write", rd, 8'h00);

    // Fill every word with a distinct value, then read all of them back.
    // Decoding or hold faults show up here.
    for (int i = 0; i < 32; i++) begin
      write_word(5'(i), 8'(i * 7 + 3));
    end
    for (int i = 0; i < 32; i++) begin
      read_word(5'(i), rd);
      expv = 8'(i * 7 + 3);
      check_eq($sformatf("fill_addr%0d", i), rd, expv);
    end

    // Test 5: write 0xAA to word 31, then reset between edges.
    write_word(5'd31, 8'hAA);
    read_word(5'd31, rd); check_eq("t5_pre_reset", rd, 8'hAA);
    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    check_eq("t5_reset_immediate", outData, 8'h00);
    // A write attempted while reset is held must be ignored.
    Address = 5'd31;
    inData  = 8'hBB;
    WE      = 1'b1;
    @(posedge Clock);
    #1;
    check_eq("t5_write_in_reset", outData, 8'h00);
    @(negedge Clock);
    WE      = 1'b0;
    Reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_word(5'(i), rd);
      check_eq($sformatf("t5_cleared%0d", i), rd, 8'h00);
    end

    // The first rising edge after reset release accepts a write.
    @(negedge Clock);
    Reset_n = 1'b0;
    #2;
    Address = 5'd4;
    inData  = 8'h44;
    WE      = 1'b1;
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    WE = 1'b0;
    read_word(5'd4, rd); check_eq("first_write_after_release", rd, 8'h44);

`ifdef RAM32X8_OUTREG_EN
    // Test 6: registered read shows word 7 one cycle after the address, not before.
    write_word(5'd7, 8'h3C);
    read_word(5'd0, rd); check_eq("t6_addr0", rd, 8'h00);
    @(negedge Clock);
    Address = 5'd7;
    #1;
    check_eq("t6_not_before", outData, 8'h00);
    @(posedge Clock);
    #1;
    check_eq("t6_after_edge", outData, 8'h3C);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
